// File: rtl/sync_pulse_gen_pkg.sv
// Default 640x480 VGA timing constants and counter helper shared by video blocks.
package sync_pulse_gen_pkg;

    localparam int CNT_W       = 10;
    localparam int TOTAL_COLS  = 800;
    localparam int TOTAL_ROWS  = 525;
    localparam int ACTIVE_COLS = 640;
    localparam int ACTIVE_ROWS = 480;

    typedef logic [CNT_W-1:0] cnt_t;

    function automatic cnt_t next_count(input cnt_t c, input logic wrap);
        return wrap ? '0 : c + 1'b1;
    endfunction

endpackage

// File: rtl/sync_pulse_gen_wrap_counter.sv
// Counter that resets to MAX and wraps MAX -> 0 on exact equality.
module wrap_counter
    import sync_pulse_gen_pkg::*;
#(
    parameter int MAX   = 799,
    parameter int WIDTH = CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    assign wrap    = (count_q == WIDTH'(MAX));
    assign count_d = wrap ? '0 : count_q + 1'b1;
    assign count   = count_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= WIDTH'(MAX);
        end else if (enable) begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/sync_pulse_gen.sv
// Free-running VGA col/row timing with registered hsync/vsync/de.
// Optional frame_start pulse when SYNC_GEN_FRAME_PULSE_EN is defined.
module sync_pulse_gen
    import sync_pulse_gen_pkg::*;
#(
    parameter int TOTAL_COLS_P  = TOTAL_COLS,
    parameter int TOTAL_ROWS_P  = TOTAL_ROWS,
    parameter int ACTIVE_COLS_P = ACTIVE_COLS,
    parameter int ACTIVE_ROWS_P = ACTIVE_ROWS
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [CNT_W-1:0] col,
    output logic [CNT_W-1:0] row
`ifdef SYNC_GEN_FRAME_PULSE_EN
    ,
    output logic             frame_start
`endif
);

    cnt_t col_q;
    cnt_t row_q;
    logic col_wrap;
    logic row_wrap;
    cnt_t col_d;
    cnt_t row_d;
    logic hsync_q;
    logic vsync_q;
    logic de_q;
    logic hsync_d;
    logic vsync_d;

    wrap_counter #(
        .MAX   (TOTAL_COLS_P - 1),
        .WIDTH (CNT_W)
    ) u_col (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .count  (col_q),
        .wrap   (col_wrap)
    );

    wrap_counter #(
        .MAX   (TOTAL_ROWS_P - 1),
        .WIDTH (CNT_W)
    ) u_row (
        .clock  (clock),
        .reset  (reset),
        .enable (enable & col_wrap),
        .count  (row_q),
        .wrap   (row_wrap)
    );

    // Look-ahead of the counters so syncs land on the same edge as col/row
    assign col_d   = next_count(col_q, col_wrap);
    assign row_d   = col_wrap ? next_count(row_q, row_wrap) : row_q;
    assign hsync_d = (col_d < CNT_W'(ACTIVE_COLS_P));
    assign vsync_d = (row_d < CNT_W'(ACTIVE_ROWS_P));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hsync_q <= 1'b0;
            vsync_q <= 1'b0;
            de_q    <= 1'b0;
        end else if (enable) begin
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= hsync_d & vsync_d;
        end
    end

`ifdef SYNC_GEN_FRAME_PULSE_EN
    logic fs_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fs_q <= 1'b0;
        end else begin
            fs_q <= enable && (col_d == '0) && (row_d == '0);
        end
    end

    assign frame_start = fs_q;
`endif

    assign hsync = hsync_q;
    assign vsync = vsync_q;
    assign de    = de_q;
    assign col   = col_q;
    assign row   = row_q;

endmodule

// File: tb/tb_sync_pulse_gen.sv
// Directed bench for sync_pulse_gen: default 640x480 instance plus a tiny 10x6 frame instance.
module tb_sync_pulse_gen;

    logic       clock;
    logic       reset;
    logic       enable;
    logic       en2;
    logic       hsync, vsync, de;
    logic [9:0] col, row;
    logic       h2, v2, de2;
    logic [9:0] c2, r2;
    logic       fs2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       en;
        int         clks;
        logic [9:0] col;
        logic [9:0] row;
        logic       h;
        logic       v;
        logic       d;
    } vec_t;

    vec_t vecs[8];

    sync_pulse_gen dut (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .hsync  (hsync),
        .vsync  (vsync),
        .de     (de),
        .col    (col),
        .row    (row)
`ifdef SYNC_GEN_FRAME_PULSE_EN
        ,
        .frame_start ()
`endif
    );

    sync_pulse_gen #(
        .TOTAL_COLS_P  (10),
        .TOTAL_ROWS_P  (6),
        .ACTIVE_COLS_P (8),
        .ACTIVE_ROWS_P (4)
    ) dut_small (
        .clock  (clock),
        .reset  (reset),
        .enable (en2),
        .hsync  (h2),
        .vsync  (v2),
        .de     (de2),
        .col    (c2),
        .row    (r2)
`ifdef SYNC_GEN_FRAME_PULSE_EN
        ,
        .frame_start (fs2)
`endif
    );

`ifndef SYNC_GEN_FRAME_PULSE_EN
    assign fs2 = 1'b0;
`endif

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [22:0] act,
                         input logic [22:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        int hcnt;
        int vcnt;
        int fcnt;
        int bad;
        int mc;
        int mr;
        vecs[0] = '{1'b1, 1,   10'd0,   10'd0, 1'b1, 1'b1, 1'b1};
        vecs[1] = '{1'b1, 638, 10'd638, 10'd0, 1'b1, 1'b1, 1'b1};
        vecs[2] = '{1'b1, 1,   10'd639, 10'd0, 1'b1, 1'b1, 1'b1};
        vecs[3] = '{1'b0, 10,  10'd639, 10'd0, 1'b1, 1'b1, 1'b1};
        vecs[4] = '{1'b1, 1,   10'd640, 10'd0, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 158, 10'd798, 10'd0, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 1,   10'd799, 10'd0, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 1,   10'd0,   10'd1, 1'b1, 1'b1, 1'b1};

        reset  = 1'b1;
        enable = 1'b1;
        en2    = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_state", {col, row, hsync, vsync, de},
              {10'd799, 10'd524, 3'b000});
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            enable = vecs[i].en;
            repeat (vecs[i].clks) @(posedge clock);
            #1;
            check($sformatf("vec%0d", i), {col, row, hsync, vsync, de},
                  {vecs[i].col, vecs[i].row, vecs[i].h, vecs[i].v, vecs[i].d});
        end

        hcnt = 0;
        for (int i = 0; i < 800; i++) begin
            @(posedge clock);
            #1;
            if (hsync) hcnt++;
        end
        check_int("hsync_per_line", hcnt, 640);

        repeat (300) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", {col, row, hsync, vsync, de},
              {10'd799, 10'd524, 3'b000});
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("restart", {col, row, hsync, vsync, de},
              {10'd0, 10'd0, 3'b111});

        hcnt = 0;
        vcnt = 0;
        fcnt = 0;
        bad  = 0;
        mc   = 9;
        mr   = 5;
        en2  = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(posedge clock);
            #1;
            if (mc == 9) begin
                mc = 0;
                mr = (mr == 5) ? 0 : mr + 1;
            end else begin
                mc = mc + 1;
            end
            if (c2 != 10'(mc) || r2 != 10'(mr) || h2 != (mc < 8) ||
                v2 != (mr < 4) || de2 != ((mc < 8) && (mr < 4)))
                bad++;
            if (h2) hcnt++;
            if (v2) vcnt++;
            if (fs2) fcnt++;
        end
        en2 = 1'b0;
        check_int("small_frame_model", bad, 0);
        check_int("small_hsync_cnt", hcnt, 48);
        check_int("small_vsync_cnt", vcnt, 40);
`ifdef SYNC_GEN_FRAME_PULSE_EN
        check_int("small_frame_start", fcnt, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
